// File: rtl/radix2_pair_buffer.sv
// Radix-2 DIF pair buffer: holds the first half of each block and pairs it with the second half.
// Optional macro PAIR_BUF_SCALE_EN halves x0/x1 (floor shift) as they load into the output register.
`timescale 1ns/1ps
module radix2_pair_buffer #(
   parameter int WIDTH = 16,
   parameter int N     = 16,
   parameter int LOG2N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_real,
   input  logic [WIDTH-1:0] in_imag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x0_real,
   output logic [WIDTH-1:0] x0_imag,
   output logic [WIDTH-1:0] x1_real,
   output logic [WIDTH-1:0] x1_imag,
   output logic [LOG2N-2:0] tw_addr,
   output logic             out_last,
   output logic             busy
);
   localparam int HALF = N / 2;
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] PAIR = 1'b1;
   localparam logic [LOG2N-2:0] CNT_LAST = (LOG2N-1)'(HALF - 1);
   localparam logic [LOG2N-2:0] CNT_ONE  = (LOG2N-1)'(1);
   localparam logic [LOG2N-2:0] CNT_ZERO = (LOG2N-1)'(0);

   logic [0:0]         state_q, state_d;
   logic [LOG2N-2:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] buf_q [HALF];
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               busy_q, busy_d;
   logic [WIDTH-1:0]   x0_real_q, x0_real_d, x0_imag_q, x0_imag_d;
   logic [WIDTH-1:0]   x1_real_q, x1_real_d, x1_imag_q, x1_imag_d;
   logic [LOG2N-2:0]   tw_q, tw_d;
   logic               in_ready_s, in_xfer_s, out_xfer_s, load_s, cnt_wrap_s;
   logic [2*WIDTH-1:0] partner_s;

   function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] v);
`ifdef PAIR_BUF_SCALE_EN
      scale = {v[WIDTH-1], v[WIDTH-1:1]};
`else
      scale = v;
`endif
   endfunction

   // Handshake decode; PAIR only takes a sample when the output register can be refilled.
   always_comb begin
      if (state_q == PAIR) begin
         in_ready_s = !out_valid_q || out_ready;
      end else begin
         in_ready_s = 1'b1;
      end
      in_xfer_s  = in_valid && in_ready_s;
      out_xfer_s = out_valid_q && out_ready;
      load_s     = in_xfer_s && (state_q == PAIR);
      cnt_wrap_s = (cnt_q == CNT_LAST);
      partner_s  = buf_q[cnt_q];
   end

   // Next-state for FSM, counter and output register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      x0_real_d   = x0_real_q;
      x0_imag_d   = x0_imag_q;
      x1_real_d   = x1_real_q;
      x1_imag_d   = x1_imag_q;
      tw_d        = tw_q;
      if (in_xfer_s) begin
         if (cnt_wrap_s) begin
            cnt_d = CNT_ZERO;
            case (state_q)
               FILL:    state_d = PAIR;
               PAIR:    state_d = FILL;
               default: state_d = FILL;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
      if (load_s) begin
         out_valid_d = 1'b1;
         x0_real_d   = scale(partner_s[2*WIDTH-1:WIDTH]);
         x0_imag_d   = scale(partner_s[WIDTH-1:0]);
         x1_real_d   = scale(in_real);
         x1_imag_d   = scale(in_imag);
         tw_d        = cnt_q;
         out_last_d  = cnt_wrap_s;
      end else if (out_xfer_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      busy_d = (cnt_d != CNT_ZERO) || (state_d == PAIR);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= CNT_ZERO;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         x0_real_q   <= '0;
         x0_imag_q   <= '0;
         x1_real_q   <= '0;
         x1_imag_q   <= '0;
         tw_q        <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         x0_real_q   <= x0_real_d;
         x0_imag_q   <= x0_imag_d;
         x1_real_q   <= x1_real_d;
         x1_imag_q   <= x1_imag_d;
         tw_q        <= tw_d;
      end
   end

   // Buffer is written only in FILL; contents need no reset since every slot is rewritten before use.
   always_ff @(posedge clk) begin
      if (in_xfer_s && (state_q == FILL)) begin
         buf_q[cnt_q] <= {in_real, in_imag};
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign x0_real   = x0_real_q;
   assign x0_imag   = x0_imag_q;
   assign x1_real   = x1_real_q;
   assign x1_imag   = x1_imag_q;
   assign tw_addr   = tw_q;

endmodule

// File: tb/tb_radix2_pair_buffer.sv
// Bench for radix2_pair_buffer: N=8 instance for directed cases, N=16 instance for random traffic.
// Expected x values follow PAIR_BUF_SCALE_EN when the bundle is built with it.
`timescale 1ns/1ps
module tb_radix2_pair_buffer;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] x0r, x0i, x1r, x1i;
      logic [3:0]   tw;
      logic         last;
   } pair_t;

   typedef struct {
      logic         iv;
      logic [W-1:0] re;
      logic         ordy;
      logic         e_ir;
      logic         e_ov;
      logic [W-1:0] e_x0r;
      logic [W-1:0] e_x1r;
      logic [3:0]   e_tw;
      logic         e_last;
      logic         e_busy;
   } vec_t;

`ifdef PAIR_BUF_SCALE_EN
   localparam logic [W-1:0] T5_A0 = 16'hFFFE;
   localparam logic [W-1:0] T5_A1 = 16'h0003;
   localparam logic [W-1:0] T5_B  = 16'hC000;
`else
   localparam logic [W-1:0] T5_A0 = 16'hFFFD;
   localparam logic [W-1:0] T5_A1 = 16'h0007;
   localparam logic [W-1:0] T5_B  = 16'h8000;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         a_iv, a_ir, a_ordy, a_ov, a_last, a_busy;
   logic [W-1:0] a_re, a_im, a_x0r, a_x0i, a_x1r, a_x1i;
   logic [1:0]   a_tw;
   logic         b_iv, b_ir, b_ordy, b_ov, b_last, b_busy;
   logic [W-1:0] b_re, b_im, b_x0r, b_x0i, b_x1r, b_x1i;
   logic [2:0]   b_tw;

   radix2_pair_buffer #(.WIDTH(W), .N(8), .LOG2N(3)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_real(a_re), .in_imag(a_im),
      .out_valid(a_ov), .out_ready(a_ordy), .x0_real(a_x0r), .x0_imag(a_x0i),
      .x1_real(a_x1r), .x1_imag(a_x1i), .tw_addr(a_tw), .out_last(a_last), .busy(a_busy));

   radix2_pair_buffer #(.WIDTH(W), .N(16), .LOG2N(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_real(b_re), .in_imag(b_im),
      .out_valid(b_ov), .out_ready(b_ordy), .x0_real(b_x0r), .x0_imag(b_x0i),
      .x1_real(b_x1r), .x1_imag(b_x1i), .tw_addr(b_tw), .out_last(b_last), .busy(b_busy));

   int errors = 0;
   int checks = 0;

   // Reference model state per instance (0 = N8, 1 = N16) and scoreboards.
   pair_t        a_q[$];
   pair_t        b_q[$];
   logic [W-1:0] m_br[2][8];
   logic [W-1:0] m_bi[2][8];
   int           m_cnt[2];
   logic         m_pair[2], m_ov[2], m_hold[2];
   pair_t        m_held[2];

   logic         s_ir, s_ov, s_busy, s_last;
   logic [W-1:0] s_x0r, s_x1r;
   logic [3:0]   s_tw;
   vec_t         tbl[10];

   function automatic logic [W-1:0] tb_sc(input logic [W-1:0] v);
`ifdef PAIR_BUF_SCALE_EN
      return {v[W-1], v[W-1:1]};
`else
      return v;
`endif
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_pair[i] = 1'b0;
         m_ov[i]   = 1'b0;
         m_hold[i] = 1'b0;
      end
      a_q.delete();
      b_q.delete();
   endtask

   task automatic observe(input int id, input int half, input logic iv, input logic [W-1:0] re,
                          input logic [W-1:0] im, input logic ordy, input logic ir, input logic ov,
                          input pair_t act, output logic acc);
      pair_t e;
      chk("in_ready", ir, !m_pair[id] || !m_ov[id] || ordy);
      chk("out_valid", ov, m_ov[id]);
      if (m_hold[id]) chk("hold_stable", {ov, act}, {1'b1, m_held[id]});
      m_hold[id] = ov && !ordy;
      m_held[id] = act;
      if (ov && ordy) begin
         if ((id == 0 ? a_q.size() : b_q.size()) == 0) begin
            chk("sb_unexpected_pair", 1'b1, 1'b0);
         end else begin
            e = (id == 0) ? a_q.pop_front() : b_q.pop_front();
            chk("sb_pair", act, e);
         end
         m_ov[id] = 1'b0;
      end
      acc = iv && ir;
      if (acc) begin
         if (!m_pair[id]) begin
            m_br[id][m_cnt[id]] = re;
            m_bi[id][m_cnt[id]] = im;
         end else begin
            e.x0r  = tb_sc(m_br[id][m_cnt[id]]);
            e.x0i  = tb_sc(m_bi[id][m_cnt[id]]);
            e.x1r  = tb_sc(re);
            e.x1i  = tb_sc(im);
            e.tw   = 4'(m_cnt[id]);
            e.last = (m_cnt[id] == half - 1);
            if (id == 0) a_q.push_back(e);
            else b_q.push_back(e);
            m_ov[id] = 1'b1;
         end
         if (m_cnt[id] == half - 1) begin
            m_cnt[id]  = 0;
            m_pair[id] = !m_pair[id];
         end else begin
            m_cnt[id]++;
         end
      end
   endtask

   task automatic step_a(input logic iv, input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic ordy, output logic acc);
      a_iv = iv; a_re = re; a_im = im; a_ordy = ordy;
      #1;
      s_ir = a_ir; s_ov = a_ov; s_busy = a_busy; s_last = a_last;
      s_x0r = a_x0r; s_x1r = a_x1r; s_tw = {2'b00, a_tw};
      observe(0, 4, iv, re, im, ordy, a_ir, a_ov, {a_x0r, a_x0i, a_x1r, a_x1i, {2'b00, a_tw}, a_last}, acc);
      @(negedge clk);
   endtask

   task automatic step_b(input logic iv, input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic ordy, output logic acc);
      b_iv = iv; b_re = re; b_im = im; b_ordy = ordy;
      #1;
      observe(1, 8, iv, re, im, ordy, b_ir, b_ov, {b_x0r, b_x0i, b_x1r, b_x1i, {1'b0, b_tw}, b_last}, acc);
      @(negedge clk);
   endtask

   task automatic send_a(input logic [W-1:0] re, input logic [W-1:0] im);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         step_a(1'b1, re, im, 1'b1, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic drain_a(input int n);
      logic acc;
      repeat (n) step_a(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
   endtask

   initial begin
      logic acc;
      int   sent, cyc;
      logic [W-1:0] rr, ri;
      logic [W-1:0] t5[8];

      //        iv    re     ordy  e_ir  e_ov  e_x0r  e_x1r  e_tw  e_last e_busy
      tbl[0] = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 16'd5, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 16'd6, 1'b1, 1'b1, 1'b1, 16'd1, 16'd5, 4'd0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 16'd7, 1'b1, 1'b1, 1'b1, 16'd2, 16'd6, 4'd1, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 16'd8, 1'b1, 1'b1, 1'b1, 16'd3, 16'd7, 4'd2, 1'b0, 1'b1};
      tbl[8] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd4, 16'd8, 4'd3, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0};

      rst = 1'b1;
      a_iv = 1'b0; a_re = '0; a_im = '0; a_ordy = 1'b0;
      b_iv = 1'b0; b_re = '0; b_im = '0; b_ordy = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_out_valid", a_ov, 1'b0);
      chk("reset_busy", a_busy, 1'b0);
      chk("reset_x", {a_x0r, a_x0i, a_x1r, a_x1i, a_tw, a_last}, '0);
      chk("reset_b_out_valid", b_ov, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: one N=8 block, out_ready high.
      for (int i = 0; i < 10; i++) begin
         step_a(tbl[i].iv, tbl[i].re, 16'h0000, tbl[i].ordy, acc);
         chk("t1_in_ready", s_ir, tbl[i].e_ir);
         chk("t1_out_valid", s_ov, tbl[i].e_ov);
         chk("t1_busy", s_busy, tbl[i].e_busy);
         if (tbl[i].e_ov) begin
            chk("t1_x0_real", s_x0r, tb_sc(tbl[i].e_x0r));
            chk("t1_x1_real", s_x1r, tb_sc(tbl[i].e_x1r));
            chk("t1_tw_addr", s_tw, tbl[i].e_tw);
            chk("t1_out_last", s_last, tbl[i].e_last);
         end
      end

      // Test 2: stall the second pair for three cycles.
      for (int k = 1; k <= 6; k++) send_a(16'(k), 16'(k * 2));
      for (int c = 0; c < 3; c++) begin
         step_a(1'b1, 16'd7, 16'd14, 1'b0, acc);
         chk("t2_stall_in_ready", s_ir, 1'b0);
         chk("t2_stall_accept", acc, 1'b0);
         chk("t2_stall_x", {s_ov, s_x0r, s_x1r}, {1'b1, tb_sc(16'd2), tb_sc(16'd6)});
      end
      send_a(16'd7, 16'd14);
      send_a(16'd8, 16'd16);
      drain_a(3);
      chk("t2_sb_empty", a_q.size(), 0);

      // Test 3: two back-to-back blocks with in_valid held high.
      for (int i = 0; i < 18; i++) begin
         if (i < 16) step_a(1'b1, 16'((i / 8) * 100 + (i % 8) + 1), 16'(i * 3), 1'b1, acc);
         else step_a(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
         chk("t3_out_valid_pattern", s_ov, (i >= 5) && (((i - 5) % 8) < 4));
         if (i < 16) chk("t3_accept", acc, 1'b1);
      end
      chk("t3_sb_empty", a_q.size(), 0);

      // Test 4: asynchronous reset after five samples of a block.
      for (int k = 0; k < 5; k++) send_a(16'(31 + k), 16'(60 + k));
      a_iv = 1'b0;
      #1;
      chk("t4_pre_out_valid", a_ov, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("t4_rst_out_valid", a_ov, 1'b0);
      chk("t4_rst_busy", a_busy, 1'b0);
      chk("t4_rst_x", {a_x0r, a_x0i, a_x1r, a_x1i, a_tw, a_last}, '0);
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) send_a(16'(41 + k), 16'(90 + k));
      drain_a(3);
      chk("t4_sb_empty", a_q.size(), 0);

      // Test 5: negative and most-negative values.
      t5[0] = 16'hFFFD; t5[1] = 16'h8000; t5[2] = 16'h0005; t5[3] = 16'hFFFF;
      t5[4] = 16'h0007; t5[5] = 16'h8000; t5[6] = 16'hFFFA; t5[7] = 16'h0000;
      for (int k = 0; k < 5; k++) send_a(t5[k], t5[k]);
      step_a(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
      chk("t5_neg_pair", {s_ov, s_x0r, s_x1r}, {1'b1, T5_A0, T5_A1});
      send_a(t5[5], t5[5]);
      step_a(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
      chk("t5_min_pair", {s_ov, s_x0r, s_x1r}, {1'b1, T5_B, T5_B});
      send_a(t5[6], t5[6]);
      send_a(t5[7], t5[7]);
      drain_a(3);
      chk("t5_sb_empty", a_q.size(), 0);

      // Test 6: N=16, 100 blocks with random gaps on both sides.
      sent = 0;
      cyc  = 0;
      rr   = 16'($urandom());
      ri   = 16'($urandom());
      while (sent < 1600 && cyc < 20000) begin
         step_b($urandom_range(0, 3) != 0, rr, ri, $urandom_range(0, 3) != 0, acc);
         cyc++;
         if (acc) begin
            sent++;
            rr = 16'($urandom());
            ri = 16'($urandom());
         end
      end
      chk("t6_all_sent", sent, 1600);
      repeat (4) step_b(1'b0, 16'h0000, 16'h0000, 1'b1, acc);
      chk("t6_sb_empty", b_q.size(), 0);
      chk("t6_idle_busy", b_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
